imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Sequencer that fills the pipeline's instruction memory from a byte-serial host stream, then releases the core to run.
- Sits between a host byte source (UART receiver or testbench) and the core's load interface (start, INSTRUCTION, ADDRESS).
- Holds the core in load mode (start=1) for the whole transfer, then drops start and pulses done.

Parameters:
- DEPTH, 1024, instruction memory size in 32-bit words; maximum legal word count.
- CNT_W, 16, width of the host-supplied word-count field.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_req  input  1  one-cycle request to begin a load; honoured only in IDLE or ERR.
- abort  input  1  cancels a load in progress and returns to IDLE.
- byte_valid  input  1  host byte available.
- byte_data  input  8  host byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- start  output  1  core load mode; high from accepted load_req until DONE/ERR/abort.
- instr_we  output  1  one-cycle instruction memory write strobe.
- address  output  32  byte address of the word being written; always 4-aligned.
- instruction  output  32  assembled instruction word.
- busy  output  1  high in every state except IDLE and ERR.
- done  output  1  one-cycle pulse when the final word has been written.
- error  output  1  high in ERR; held until the next accepted load_req or reset.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; word index, byte index, length and shift register cleared. Assertion mid-load discards the load with no further writes.
- A byte transfers on a rising edge when byte_valid && byte_ready. byte_ready is 1 only in LEN_LO, LEN_HI and BYTE, and 0 in every other state.
- Stream format, little-endian: count[7:0], count[15:8], then count words of 4 bytes each, least significant byte first.
- IDLE: load_req -> LEN_LO, start=1, error=0.
- LEN_LO: on transfer, latch the low count byte -> LEN_HI.
- LEN_HI: on transfer, latch the high count byte -> CHECK.
- CHECK (1 cycle): count==0 or count>DEPTH -> ERR. Otherwise clear the word index -> BYTE.
- BYTE: each transfer shifts into instruction[8*k+:8], where k is the byte index 0..3. The 4th transfer -> WRITE.
- WRITE (1 cycle): instr_we=1; address = word_index*4; instruction holds the assembled word, stable for this cycle.
  - If word_index == count-1 -> DONE.
  - Otherwise increment word_index, clear the byte index -> BYTE.
- DONE (1 cycle): done=1, start=0 -> IDLE.
- ERR: start=0, error=1, no writes. load_req -> LEN_LO, clears error.
- Latency: the write strobe occurs the cycle after the 4th byte of a word is accepted. With byte_valid held high, each word takes 5 cycles.
- byte_valid low stalls the FSM in place; partial words are retained across gaps of any length.
- abort has priority over all other inputs in every non-IDLE state: next state IDLE, start=0, no write that cycle, no done, error unchanged (0). abort in IDLE is ignored.
- load_req while busy is ignored.
- Simultaneous load_req and abort in ERR: abort ignored (ERR is not busy), load_req honoured.
- address arithmetic is 32-bit; word_index width is clog2(DEPTH)+1, so DEPTH words never wrap.
- instruction and address hold their last values outside WRITE.

Test Plan:
- Load count=2 with bytes 02 00 | 13 05 10 00 | 93 05 20 00 -> writes (addr 0x0, data 0x00100513) then (0x4, 0x00200593); done pulses one cycle after the second write; start falls with done.
- Count bytes 00 00 -> ERR: error=1, start=0, no instr_we. A following load_req clears error and re-enters LEN_LO.
- Count = DEPTH+1 (0x0401) -> ERR. Count = DEPTH (0x0400) with random data -> 1024 writes, last at address 0xFFC, then done.
- Deassert byte_valid randomly between bytes of count=3 -> identical write data and addresses as the gap-free run; no strobe during gaps.
- abort after the 2nd byte of word 1 -> IDLE next cycle, start=0, no further instr_we, done never asserts. A new load from word 0 succeeds.
- rst_n low mid-word -> all outputs 0 immediately; load_req pulses during BYTE are ignored (no restart, write addresses continue sequentially).

Source files
------------

// File: rtl/imem_boot_loader.sv
// Byte-serial instruction memory loader: reads a little-endian word count and
// that many 32-bit words from the host, strobing each assembled word into imem.
module imem_boot_loader #(
  parameter int DEPTH = 1024,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_req,
  input  logic        abort,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        start,
  output logic        instr_we,
  output logic [31:0] address,
  output logic [31:0] instruction,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int WIDX_W = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_CHECK, S_BYTE, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic [1:0]          bidx_q, bidx_d;
  logic [23:0]         shift_q, shift_d;
  logic [31:0]         instr_q, instr_d;
  logic [31:0]         addr_q, addr_d;

  logic in_load;
  logic xfer;
  logic len_bad;
  logic last_word;

  // abort is only meaningful while busy; ERR keeps error until a new load_req
  assign in_load   = (state_q != S_IDLE) && (state_q != S_ERR);
  assign len_bad   = (len_q == '0) || (32'(len_q) > 32'(DEPTH));
  assign last_word = (CNT_W'(widx_q) == (len_q - CNT_W'(1)));

  assign byte_ready  = ((state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_BYTE)) && !abort;
  assign xfer        = byte_valid && byte_ready;
  assign start       = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                       (state_q == S_CHECK)  || (state_q == S_BYTE)   ||
                       (state_q == S_WRITE);
  assign busy        = in_load;
  assign instr_we    = (state_q == S_WRITE) && !abort;
  assign done        = (state_q == S_DONE) && !abort;
  assign error       = (state_q == S_ERR);
  assign instruction = instr_q;
  assign address     = addr_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    shift_d = shift_q;
    instr_d = instr_q;
    addr_d  = addr_q;

    if (abort && in_load) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_ERR: begin
          if (load_req) begin
            state_d = S_LEN_LO;
            bidx_d  = '0;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len_d[7:0] = byte_data;
            state_d    = S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_d[CNT_W-1:8] = (CNT_W-8)'(byte_data);
            state_d          = S_CHECK;
          end
        end
        S_CHECK: begin
          if (len_bad) begin
            state_d = S_ERR;
          end else begin
            widx_d  = '0;
            bidx_d  = '0;
            state_d = S_BYTE;
          end
        end
        S_BYTE: begin
          if (xfer) begin
            unique case (bidx_q)
              2'd0: shift_d[7:0]   = byte_data;
              2'd1: shift_d[15:8]  = byte_data;
              2'd2: shift_d[23:16] = byte_data;
              default: begin
                // output registers only change on word completion so they hold outside WRITE
                instr_d = {byte_data, shift_q};
                addr_d  = 32'(widx_q) << 2;
                state_d = S_WRITE;
              end
            endcase
            bidx_d = bidx_q + 2'd1;
          end
        end
        S_WRITE: begin
          if (last_word) begin
            state_d = S_DONE;
          end else begin
            widx_d  = widx_q + WIDX_W'(1);
            bidx_d  = '0;
            state_d = S_BYTE;
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      shift_q <= '0;
      instr_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      shift_q <= shift_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares every instr_we and done pulse.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_req, abort, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, start, instr_we, busy, done, error;
  logic [31:0] address, instruction;

  imem_boot_loader #(.DEPTH(1024), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .start(start), .instr_we(instr_we), .address(address),
    .instruction(instruction), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    bit          last;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_wr    = 0;
  bit   done_exp = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every write must match the head of the scoreboard; done only after a last word
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        done_exp = 1'b0;
      end else begin
        if (done_exp) begin
          chk("done_after_last", 64'(done), 64'd1);
          chk("start_low_with_done", 64'(start), 64'd0);
          done_exp = 1'b0;
        end else if (done) begin
          n_total++;
          $display("FAIL unexpected_done: got done=1 expected 0");
        end
        if (instr_we) begin
          if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write", address, instruction);
          end else begin
            e = sb.pop_front();
            chk("wr_addr", 64'(address), 64'(e.a));
            chk("wr_data", 64'(instruction), 64'(e.d));
            n_wr++;
            if (e.last) done_exp = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int  n;
    bit  ok;
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    do begin
      ok = byte_ready;
      tick();
      n++;
    end while (!ok && n < 50);
    byte_valid = 1'b0;
    if (!ok) begin
      n_total++;
      $display("FAIL byte_accept_timeout: got no byte_ready expected handshake within 50 cycles");
    end
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic send_count(input logic [15:0] c);
    send_byte(c[7:0], 0);
    send_byte(c[15:8], 0);
  endtask

  task automatic send_word(input logic [31:0] a, input logic [31:0] d, input bit last, input int gap);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        e.a = a; e.d = d; e.last = last;
        sb.push_back(e);
      end
      send_byte(d[8*k +: 8], (gap + k) % 3);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk(name, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] d;
    rst_n = 1'b0; load_req = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", 64'({byte_ready, start, instr_we, busy, done, error}), 64'd0);
    chk("rst_addr", 64'(address), 64'd0);
    chk("rst_instr", 64'(instruction), 64'd0);
    rst_n = 1'b1;
    tick();

    // Two-word program
    pulse_load();
    chk("load_start", 64'({start, busy, error, byte_ready}), 64'b1101);
    send_count(16'd2);
    send_word(32'h0, 32'h00100513, 1'b0, 0);
    send_word(32'h4, 32'h00200593, 1'b1, 0);
    wait_idle("idle_after_two");
    chk("start_after_done", 64'(start), 64'd0);
    chk("sb_empty_two", 64'(sb.size()), 64'd0);

    // Zero count -> ERR, then recover, then DEPTH+1 -> ERR
    pulse_load();
    send_count(16'h0000);
    tick(); tick();
    chk("err_zero", 64'({error, start, busy, byte_ready}), 64'b1000);
    pulse_load();
    chk("err_cleared_len_lo", 64'({error, start, byte_ready}), 64'b011);
    send_count(16'h0401);
    tick(); tick();
    chk("err_depth_plus1", 64'({error, start, busy}), 64'b100);

    // Full DEPTH load (load_req from ERR)
    pulse_load();
    chk("err_cleared_depth", 64'(error), 64'd0);
    n_wr = 0;
    send_count(16'h0400);
    for (int i = 0; i < 1024; i++) begin
      d = 32'h9E3779B9 * 32'(i) + 32'h0000_1234;
      send_word(32'(i) * 4, d, i == 1023, 0);
    end
    wait_idle("idle_after_depth");
    chk("depth_writes", 64'(n_wr), 64'd1024);
    chk("depth_last_addr", 64'(address), 64'hFFC);

    // Count 3 with gaps between bytes
    pulse_load();
    send_count(16'd3);
    send_word(32'h0, 32'hDEADBEEF, 1'b0, 1);
    send_word(32'h4, 32'h12345678, 1'b0, 2);
    send_word(32'h8, 32'hCAFE00FF, 1'b1, 4);
    wait_idle("idle_after_gaps");
    chk("sb_empty_gaps", 64'(sb.size()), 64'd0);

    // Abort after 2nd byte of word 1
    pulse_load();
    send_count(16'd3);
    send_word(32'h0, 32'hA1B2C3D4, 1'b0, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", 64'({busy, start, error}), 64'b000);
    byte_valid = 1'b1; byte_data = 8'h33;
    repeat (10) tick();
    byte_valid = 1'b0;
    chk("abort_stays_idle", 64'({busy, start, error, byte_ready}), 64'b0000);
    pulse_load();
    send_count(16'd1);
    send_word(32'h0, 32'h0BADF00D, 1'b1, 0);
    wait_idle("idle_after_reload");

    // load_req during BYTE ignored, then async reset mid-word
    pulse_load();
    send_count(16'd3);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    pulse_load();
    chk("load_ignored_busy", 64'({start, busy, byte_ready}), 64'b111);
    send_byte(8'h34, 0);
    begin
      exp_t e;
      e.a = 32'h0; e.d = 32'h12345678; e.last = 1'b0;
      sb.push_back(e);
    end
    send_byte(8'h12, 0);
    send_word(32'h4, 32'h55AA33CC, 1'b0, 0);
    send_byte(8'hEE, 0);
    send_byte(8'hDD, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", 64'({byte_ready, start, instr_we, busy, done, error}), 64'd0);
    chk("midrst_data", 64'({address, instruction}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    byte_valid = 1'b1; byte_data = 8'hCC;
    repeat (8) tick();
    byte_valid = 1'b0;
    chk("post_rst_idle", 64'({busy, start, address}), 64'd0);
    chk("sb_empty_end", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
